// File: rtl/bram_rd_arbiter.sv
// Purpose: shares one synchronous BRAM read port between client A (scan-out) and client B (colour-map).
// Latency: grant in cycle N -> rd_valid_x in cycle N+2, fixed regardless of contention.
// Backpressure: req/gnt handshake; a losing client holds req+addr until granted; responses cannot be stalled.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   rd_req_x / rd_addr_x     client read request and address (x = a, b), held until rd_gnt_x
//   rd_gnt_x                 combinational grant, forced low during reset
//   rd_valid_x / rd_data_x   one-cycle response pulse; data held between pulses
//   rd_err_x                 pulses with rd_valid_x when the address was >= DEPTH
//   bram_addr_read           BRAM read address (holds its last value when idle)
//   bram_data_out            BRAM read data, one cycle after bram_addr_read
//
// Build option: define RD_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise client A has fixed priority and no pointer register exists.

module bram_rd_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 768,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             rd_req_a,
    input  logic [ADDRW-1:0] rd_addr_a,
    output logic             rd_gnt_a,
    output logic             rd_valid_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_err_a,

    input  logic             rd_req_b,
    input  logic [ADDRW-1:0] rd_addr_b,
    output logic             rd_gnt_b,
    output logic             rd_valid_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_err_b,

    output logic [ADDRW-1:0] bram_addr_read,
    input  logic [WIDTH-1:0] bram_data_out
);

    // One extra bit so DEPTH itself is representable even when DEPTH is a power of two.
    localparam logic [ADDRW:0] DEPTH_W = (ADDRW+1)'(DEPTH);

    logic             sel_b;        // B wins the port this cycle (only meaningful with a request)
    logic             gnt_any;
    logic [ADDRW-1:0] gnt_addr;
    logic             gnt_oor;      // granted address lies outside the frame buffer
    logic [ADDRW-1:0] gnt_addr_safe;
    logic [ADDRW-1:0] addr_hold;

    logic             s1_valid;
    logic             s1_client;    // 0 = A, 1 = B
    logic             s1_err;

`ifdef RD_ARB_ROUND_ROBIN_EN
    // prio_b is the inverse view of the last-granted pointer: after A is granted,
    // B has priority on the next contention. Reset leaves A with priority, so
    // continuous contention from reset yields A,B,A,B.
    logic prio_b;

    always_comb begin
        sel_b = rd_req_b & (~rd_req_a | prio_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (gnt_any) begin
            prio_b <= rd_gnt_a;
        end
    end
`else
    // Fixed priority: B only gets the port when A is idle.
    always_comb begin
        sel_b = rd_req_b & ~rd_req_a;
    end
`endif

    assign rd_gnt_a = ~rst & rd_req_a & ~sel_b;
    assign rd_gnt_b = ~rst & sel_b;
    assign gnt_any  = rd_gnt_a | rd_gnt_b;

    assign gnt_addr      = sel_b ? rd_addr_b : rd_addr_a;
    assign gnt_oor       = ({1'b0, gnt_addr} >= DEPTH_W);
    // Out-of-range reads still occupy a slot but never touch a real location.
    assign gnt_addr_safe = gnt_oor ? '0 : gnt_addr;

    // The read address is combinational on a grant and parks on the last value otherwise.
    assign bram_addr_read = gnt_any ? gnt_addr_safe : addr_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold <= '0;
        end else if (gnt_any) begin
            addr_hold <= gnt_addr_safe;
        end
    end

    // Tag stage: travels alongside the BRAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_client <= 1'b0;
            s1_err    <= 1'b0;
        end else begin
            s1_valid  <= gnt_any;
            s1_client <= rd_gnt_b;
            s1_err    <= gnt_oor;
        end
    end

    // Response stage: only the tagged client's data register is written,
    // so the other client keeps its last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_a <= 1'b0;
            rd_err_a   <= 1'b0;
            rd_data_a  <= '0;
            rd_valid_b <= 1'b0;
            rd_err_b   <= 1'b0;
            rd_data_b  <= '0;
        end else begin
            rd_valid_a <= s1_valid & ~s1_client;
            rd_err_a   <= s1_valid & ~s1_client & s1_err;
            rd_valid_b <= s1_valid & s1_client;
            rd_err_b   <= s1_valid & s1_client & s1_err;
            if (s1_valid && !s1_client) begin
                rd_data_a <= s1_err ? '0 : bram_data_out;
            end
            if (s1_valid && s1_client) begin
                rd_data_b <= s1_err ? '0 : bram_data_out;
            end
        end
    end

endmodule
